// File: rtl/vga_timing_pkg.sv
// Shared raster timing types, the per-axis region decoder and the 640x480@60 defaults.
package vga_timing_pkg;

  typedef enum logic [1:0] {SYNC, BACK, VISIBLE, FRONT} region_t;

  typedef struct packed {
    int unsigned sync;
    int unsigned back;
    int unsigned visible;
    int unsigned front;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
  } vga_timing_t;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;
  localparam int unsigned DEF_SCALE_X   = 5;
  localparam int unsigned DEF_SCALE_Y   = 5;

  // Regions run sync, back porch, visible, front porch from position 0.
  function automatic region_t decode(input logic [31:0] cnt, input axis_timing_t t);
    if (cnt < t.sync)
      return SYNC;
    else if (cnt < t.sync + t.back)
      return BACK;
    else if (cnt < t.sync + t.back + t.visible)
      return VISIBLE;
    else
      return FRONT;
  endfunction

endpackage

// File: rtl/scaled_axis_counter.sv
// Down-scaled coordinate for one axis: a phase counter divides visible steps by SCALE.
module scaled_axis_counter #(
  parameter int unsigned SCALE   = 5,
  parameter int unsigned VISIBLE = 640,
  parameter int unsigned OUT_W   = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             advance,
  input  logic             in_window,
  input  logic             window_start,
  output logic [OUT_W-1:0] scl_cnt
);

  localparam int unsigned PW   = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int unsigned LAST = (VISIBLE + SCALE - 1) / SCALE - 1;

  logic [PW-1:0]    phase_d, phase_q;
  logic [OUT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (advance) begin
      if (!in_window || window_start) begin
        phase_d = '0;
        cnt_d   = '0;
      end else if (phase_q == PW'(SCALE - 1)) begin
        phase_d = '0;
        // The last column may be partial; never count past it.
        if (cnt_q != OUT_W'(LAST))
          cnt_d = cnt_q + 1'b1;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= '0;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  assign scl_cnt = cnt_q;

endmodule

// File: rtl/vga_timing_generator.sv
// Raster timing generator: H/V counters, syncs, display enable, scaled coordinates and markers.
// All outputs are registered from the next-state counters so they stay coherent with hor/ver.
module vga_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter int unsigned SCALE_X   = DEF_SCALE_X,
  parameter int unsigned SCALE_Y   = DEF_SCALE_Y,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int unsigned HW       = $clog2(H_TOTAL),
  localparam int unsigned VW       = $clog2(V_TOTAL),
  localparam int unsigned SXN      = (H_VISIBLE + SCALE_X - 1) / SCALE_X,
  localparam int unsigned SYN      = (V_VISIBLE + SCALE_Y - 1) / SCALE_Y,
  localparam int unsigned SXW      = (SXN > 1) ? $clog2(SXN) : 1,
  localparam int unsigned SYW      = (SYN > 1) ? $clog2(SYN) : 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           ce,
  output logic [HW-1:0]  hor_cnt,
  output logic [VW-1:0]  ver_cnt,
  output logic [SXW-1:0] scl_hor_cnt,
  output logic [SYW-1:0] scl_ver_cnt,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic           line_start,
  output logic           frame_start
);

  localparam axis_timing_t H_TIM = '{sync: H_SYNC, back: H_BACK, visible: H_VISIBLE, front: H_FRONT};
  localparam axis_timing_t V_TIM = '{sync: V_SYNC, back: V_BACK, visible: V_VISIBLE, front: V_FRONT};

  logic [HW-1:0] hor_d, hor_q;
  logic [VW-1:0] ver_d, ver_q;
  logic          hsync_d, hsync_q;
  logic          vsync_d, vsync_q;
  logic          de_d, de_q;
  logic          line_start_d, line_start_q;
  logic          frame_start_d, frame_start_q;
  logic          h_wrap, v_wrap;
  logic          h_vis_d, v_vis_d;
  logic          h_start_d, v_start_d;

  always_comb begin
    h_wrap        = (hor_q == HW'(H_TOTAL - 1));
    v_wrap        = (ver_q == VW'(V_TOTAL - 1));
    hor_d         = hor_q;
    ver_d         = ver_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    if (ce) begin
      hor_d = h_wrap ? '0 : hor_q + 1'b1;
      if (h_wrap)
        ver_d = v_wrap ? '0 : ver_q + 1'b1;
      line_start_d  = h_wrap;
      frame_start_d = h_wrap && v_wrap;
    end
    // Decoding the held position when ce is low reproduces the current outputs.
    h_vis_d   = (decode(32'(hor_d), H_TIM) == VISIBLE);
    v_vis_d   = (decode(32'(ver_d), V_TIM) == VISIBLE);
    h_start_d = (hor_d == HW'(H_SYNC + H_BACK));
    v_start_d = (ver_d == VW'(V_SYNC + V_BACK));
    hsync_d   = (decode(32'(hor_d), H_TIM) == SYNC) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d   = (decode(32'(ver_d), V_TIM) == SYNC) ? VSYNC_POL : ~VSYNC_POL;
    de_d      = h_vis_d && v_vis_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hor_q         <= '0;
      ver_q         <= '0;
      hsync_q       <= HSYNC_POL;
      vsync_q       <= VSYNC_POL;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hor_q         <= hor_d;
      ver_q         <= ver_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  scaled_axis_counter #(
    .SCALE   (SCALE_X),
    .VISIBLE (H_VISIBLE),
    .OUT_W   (SXW)
  ) u_scl_x (
    .clk          (clk),
    .reset_n      (reset_n),
    .advance      (ce),
    .in_window    (h_vis_d),
    .window_start (h_start_d),
    .scl_cnt      (scl_hor_cnt)
  );

  // The row counter only steps when a line wraps.
  scaled_axis_counter #(
    .SCALE   (SCALE_Y),
    .VISIBLE (V_VISIBLE),
    .OUT_W   (SYW)
  ) u_scl_y (
    .clk          (clk),
    .reset_n      (reset_n),
    .advance      (ce && h_wrap),
    .in_window    (v_vis_d),
    .window_start (v_start_d),
    .scl_cnt      (scl_ver_cnt)
  );

  assign hor_cnt     = hor_q;
  assign ver_cnt     = ver_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_generator.md
# vga_timing_generator

Parametrised raster timing generator producing horizontal and vertical counters, sync pulses, display-enable and down-scaled pixel coordinates for the VGA output path. It is the next generation of the horizontal-only counter: it covers both axes, makes every timing field and the scale factors parameters, adds a pixel clock-enable and programmable sync polarity, and drives line and frame markers for the frame-buffer reader and the colour pipeline.

## Interface
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SCALE_X, 5, visible pixels per scaled column (≥1)
- SCALE_Y, 5, visible lines per scaled row (≥1)
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync
- Derived: H_TOTAL = sum of the H fields; V_TOTAL = sum of the V fields; HW = $clog2(H_TOTAL); VW = $clog2(V_TOTAL); SXW = $clog2(ceil(H_VISIBLE/SCALE_X)); SYW = $clog2(ceil(V_VISIBLE/SCALE_Y)).
- clk  input  1  pixel clock
- reset_n  input  1  asynchronous, active-low reset
- ce  input  1  pixel enable; all state advances only when high
- hor_cnt  output  HW  horizontal position, 0..H_TOTAL-1
- ver_cnt  output  VW  vertical position, 0..V_TOTAL-1
- scl_hor_cnt  output  SXW  scaled column, 0..ceil(H_VISIBLE/SCALE_X)-1
- scl_ver_cnt  output  SYW  scaled row, 0..ceil(V_VISIBLE/SCALE_Y)-1
- hsync  output  1  horizontal sync, polarity HSYNC_POL
- vsync  output  1  vertical sync, polarity VSYNC_POL
- de  output  1  display enable (visible region)
- line_start  output  1  one-ce-cycle pulse at hor_cnt wrap to 0
- frame_start  output  1  one-ce-cycle pulse at hor_cnt and ver_cnt both wrapping to 0

## Operation
- Region order on both axes: sync, back porch, visible, front porch. Visible window is H_SYNC+H_BACK .. H_SYNC+H_BACK+H_VISIBLE-1; the vertical window is defined the same way.
- On a ce cycle, hor_cnt increments. At H_TOTAL-1 it wraps to 0 and ver_cnt increments. ver_cnt wraps at V_TOTAL-1.
- hsync is active when hor_cnt < H_SYNC. vsync is active when ver_cnt < V_SYNC. Both are full-line and full-frame aligned; there is no half-line offset.
- de = horizontal visible AND vertical visible.
- scl_hor_cnt:
  - 0 outside the horizontal visible window.
  - Within the window, it increments after every SCALE_X visible pixels, tracked by an internal phase counter 0..SCALE_X-1.
  - The phase counter resets at the first visible pixel.
  - If H_VISIBLE is not a multiple of SCALE_X, the last column is partial.
- scl_ver_cnt: same rule applied per visible line with SCALE_Y. It holds through horizontal blanking and is 0 outside the vertical window.
- ce low: every output and every internal counter holds. Pulses stay at their current value; they do not extend, because they only change on ce cycles.
- Reset:
  - Counters, phase counters and scaled counts all 0.
  - hsync = HSYNC_POL and vsync = VSYNC_POL (position 0 is inside sync).
  - de = 0.
  - line_start and frame_start are 0. They first assert on the first wrap, not on reset release.
- Reset mid-frame: all state returns to the reset values immediately (asynchronously). The first ce after release advances hor_cnt to 1.

## Timing
- Every output is registered and decoded from next-state counter values, so hsync, vsync, de, the scaled counts and the pulses are coherent with hor_cnt/ver_cnt in the same cycle. There are no combinational output paths.
- Latency from a ce edge to the updated outputs: 1 clk.
- line_start is high exactly while hor_cnt == 0 following a wrap; frame_start additionally requires ver_cnt == 0.
- At default parameters: 800 × 525 = 420000 ce cycles per frame.

## Structure
- Shared package vga_timing_pkg:
  - struct vga_timing_t holding the eight timing fields.
  - function region_t decode(cnt, timing), where region_t is the enum {SYNC, BACK, VISIBLE, FRONT}.
  - Default 640×480@60 constants.
- Sub-module scaled_axis_counter, instantiated twice (X and Y):
  - Parameters: SCALE, VISIBLE, OUT_W.
  - Inputs: advance, in_window, window_start.
  - Contains the phase counter and the scaled count.

## Test plan
- Defaults, ce tied high, 2 frames:
  - hsync low for hor_cnt 0..95 and high for 96..799.
  - de first high at hor_cnt = 144, ver_cnt = 35.
  - frame_start period exactly 420000 cycles.
- Scaling (defaults): scl_hor_cnt = 0 at hor_cnt 144..148, 1 at 149, 127 at 779..783, and 0 at 784.
  - scl_ver_cnt reaches 95 on lines 510..514.
- ce toggled 1-of-3 cycles: all outputs change only on ce cycles, and the sequence matches the ce-high run cycle-for-cycle.
- reset_n pulsed low at hor_cnt = 400, ver_cnt = 200, asynchronous to clk:
  - Outputs go to reset values before the next edge.
  - First line_start appears 800 ce cycles after release.
- Non-default parameters: H 100/4/8/4, V 50/2/2/2, SCALE_X = 3, HSYNC_POL = 1:
  - hsync high for hor_cnt 0..7.
  - Last scaled column is 33 and has width 1.
  - Wrap occurs at hor_cnt = 115 and ver_cnt = 55.
